// File: rtl/ofm_addr_pkg.sv
// Shared types, default geometry and helpers for the OFM write-address generator.
package ofm_addr_pkg;

  localparam int DEF_ADDR_WIDTH    = 22;
  localparam int DEF_SYSTOLIC_SIZE = 16;
  localparam int DEF_MAX_OFM_SIZE  = 416;
  localparam int DEF_MAX_CHANNEL   = 1024;

  localparam int SIZE_W = $clog2(DEF_MAX_OFM_SIZE + 1);
  localparam int CH_W   = $clog2(DEF_MAX_CHANNEL + 1);
  localparam int LEN_W  = $clog2(DEF_SYSTOLIC_SIZE + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Words left in the plane from the current tile start, capped at one tile.
  function automatic int unsigned calc_burst_len(input int unsigned remain,
                                                 input int unsigned s);
    return (remain < s) ? remain : s;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// OFM write-address generator: walks channel groups, pixel tiles and channels
// per accepted result beat and emits burst addresses through one register slice.
module ofm_addr_gen
  import ofm_addr_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int MAX_OFM_SIZE  = DEF_MAX_OFM_SIZE,
  parameter int MAX_CHANNEL   = DEF_MAX_CHANNEL
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  cfg_base_addr,
  input  logic [$clog2(MAX_OFM_SIZE+1)-1:0]      cfg_ofm_size,
  input  logic [$clog2(MAX_CHANNEL+1)-1:0]       cfg_num_ch,
  input  logic                                   write,
  output logic                                   write_ready,
  input  logic                                   ofm_ready,
  output logic [ADDR_WIDTH-1:0]                  ofm_addr,
  output logic [$clog2(SYSTOLIC_SIZE+1)-1:0]     burst_len,
  output logic                                   addr_valid,
  output logic                                   busy,
  output logic                                   done
);

  localparam int SW = $clog2(MAX_OFM_SIZE + 1);
  localparam int CW = $clog2(MAX_CHANNEL + 1);
  localparam int LW = $clog2(SYSTOLIC_SIZE + 1);
  localparam int KW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;

  localparam logic [ADDR_WIDTH-1:0] S_ADDR = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [CW:0]           S_CH   = (CW + 1)'(SYSTOLIC_SIZE);
  localparam logic [KW-1:0]         K_LAST = KW'(SYSTOLIC_SIZE - 1);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_r;
  logic [SW-1:0]         size_r;
  logic [CW-1:0]         ch_r;
  logic [ADDR_WIDTH-1:0] plane;
  logic [2*SW-1:0]       plane_sq;

  // Address = base + group_base + ch_off + tile_off, all built with adders.
  logic [ADDR_WIDTH-1:0] group_base;
  logic [ADDR_WIDTH-1:0] tile_off;
  logic [ADDR_WIDTH-1:0] ch_off;
  logic [KW-1:0]         k;
  logic [CW:0]           ch_base;

  logic [ADDR_WIDTH-1:0] remain;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic [CW:0]           ch_idx;
  logic                  k_last, last_tile, last_group, final_beat, masked, accept;

  assign plane_sq   = size_r * size_r;
  assign remain     = plane - tile_off;
  assign addr_calc  = base_r + group_base + ch_off + tile_off;
  assign ch_idx     = ch_base + (CW + 1)'(k);
  assign k_last     = (k == K_LAST);
  assign last_tile  = (remain <= S_ADDR);
  assign last_group = ((ch_base + S_CH) >= (CW + 1)'(ch_r));
  assign final_beat = k_last && last_tile && last_group;
  assign masked     = (ch_idx >= (CW + 1)'(ch_r));

  assign write_ready = (state == ST_RUN) && (!addr_valid || ofm_ready);
  assign accept      = write && write_ready;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = (size_r == '0 || ch_r == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (accept && final_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!addr_valid || ofm_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r     <= '0;
      size_r     <= '0;
      ch_r       <= '0;
      plane      <= '0;
      group_base <= '0;
      tile_off   <= '0;
      ch_off     <= '0;
      k          <= '0;
      ch_base    <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        base_r     <= cfg_base_addr;
        size_r     <= cfg_ofm_size;
        ch_r       <= cfg_num_ch;
        group_base <= '0;
        tile_off   <= '0;
        ch_off     <= '0;
        k          <= '0;
        ch_base    <= '0;
      end
      if (state == ST_SETUP) plane <= ADDR_WIDTH'(plane_sq);
      if (accept) begin
        if (!k_last) begin
          k      <= k + KW'(1);
          ch_off <= ch_off + plane;
        end else begin
          k      <= '0;
          ch_off <= '0;
          if (!last_tile) begin
            tile_off <= tile_off + S_ADDR;
          end else begin
            tile_off <= '0;
            // ch_off + plane here equals S*plane, the stride to the next group.
            if (!last_group) begin
              group_base <= group_base + ch_off + plane;
              ch_base    <= ch_base + S_CH;
            end
          end
        end
      end
    end
  end

  // Output register slice: masked beats are consumed but leave the slot empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_valid <= 1'b0;
      ofm_addr   <= '0;
      burst_len  <= '0;
    end else if (accept) begin
      addr_valid <= !masked;
      if (!masked) begin
        ofm_addr  <= addr_calc;
        burst_len <= LW'(calc_burst_len(32'(remain), SYSTOLIC_SIZE));
      end
    end else if (ofm_ready) begin
      addr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofm_addr_gen.sv
// Scoreboard bench for ofm_addr_gen: directed layers push expected bursts,
// a monitor pops and compares each address handed to the memory writer.
module tb_ofm_addr_gen;
  import ofm_addr_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     cfg_base_addr;
  logic [SIZE_W-1:0] cfg_ofm_size;
  logic [CH_W-1:0]   cfg_num_ch;
  logic              write;
  logic              write_ready;
  logic              ofm_ready;
  logic [AW-1:0]     ofm_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              addr_valid;
  logic              busy;
  logic              done;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  ofm_addr_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_ofm_size (cfg_ofm_size),
    .cfg_num_ch   (cfg_num_ch),
    .write        (write),
    .write_ready  (write_ready),
    .ofm_ready    (ofm_ready),
    .ofm_addr     (ofm_addr),
    .burst_len    (burst_len),
    .addr_valid   (addr_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [LEN_W-1:0] l);
    exp_t e;
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 2 units after the falling edge, after all stimulus settles.
  logic          stalled_prev = 1'b0;
  logic [AW-1:0] addr_prev;
  logic [LEN_W-1:0] len_prev;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("stall_addr_hold", 32'(ofm_addr), 32'(addr_prev));
        check("stall_len_hold", 32'(burst_len), 32'(len_prev));
        check("stall_valid_hold", 32'(addr_valid), 32'd1);
      end
      if (addr_valid && !ofm_ready) check("stall_write_ready", 32'(write_ready), 32'd0);
      if (addr_valid && ofm_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_addr got=0x%0h len=%0d want=none", ofm_addr, burst_len);
        end else begin
          e = exp_q.pop_front();
          check("ofm_addr", 32'(ofm_addr), 32'(e.addr));
          check("burst_len", 32'(burst_len), 32'(e.len));
        end
      end
      if (done) done_cnt++;
      stalled_prev = addr_valid && !ofm_ready;
      addr_prev    = ofm_addr;
      len_prev     = burst_len;
    end
  end

  task automatic start_layer(input logic [AW-1:0] base, input int w, input int c);
    @(negedge clk); #1;
    cfg_base_addr = base;
    cfg_ofm_size  = SIZE_W'(w);
    cfg_num_ch    = CH_W'(c);
    start         = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Offers beats continuously; a beat counts when write_ready is seen high.
  task automatic run_beats(input int n);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 3000) begin
      @(negedge clk); #1;
      write = 1'b1;
      if (write_ready) cnt++;
      cyc++;
    end
    @(negedge clk); #1;
    write = 1'b0;
    check("beats_accepted", 32'(cnt), 32'(n));
  endtask

  // Called one cycle after the final beat with ofm_ready high: DRAIN, then DONE.
  task automatic finish_layer();
    check("drain_done_low", 32'(done), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_write_ready", 32'(write_ready), 32'd0);
    @(negedge clk); #1;
    check("done_pulse", 32'(done), 32'd1);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_scenario1();
    for (int i = 0; i < 16; i++) push_exp(AW'(32'h100 + 16 * i), LEN_W'(16));
  endtask

  task automatic zero_layer(input int w, input int c);
    start_layer(AW'(32'h40), w, c);
    check("zero_setup_done_low", 32'(done), 32'd0);
    @(negedge clk); #1;
    check("zero_done_pulse", 32'(done), 32'd1);
    check("zero_write_ready", 32'(write_ready), 32'd0);
    @(negedge clk); #1;
    check("zero_idle", 32'(busy), 32'd0);
    check("zero_no_valid", 32'(addr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    write         = 1'b0;
    ofm_ready     = 1'b1;
    cfg_base_addr = '0;
    cfg_ofm_size  = '0;
    cfg_num_ch    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr", 32'(ofm_addr), 32'd0);
    check("rst_len", 32'(burst_len), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_write_ready", 32'(write_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Scenario 1: W=4, C=16, base 0x100 -> 16 contiguous full bursts.
    push_scenario1();
    start_layer(AW'(32'h100), 4, 16);
    run_beats(16);
    finish_layer();

    // Scenario 2: W=5 (plane 25), C=1 -> two valid bursts of 16 and 9 words.
    push_exp(AW'(32'h2000), LEN_W'(16));
    push_exp(AW'(32'h2010), LEN_W'(9));
    start_layer(AW'(32'h2000), 5, 1);
    run_beats(32);
    finish_layer();

    // Scenario 3: W=4, C=20, base 0 -> partial second group, 20 valid.
    for (int ch = 0; ch < 20; ch++) push_exp(AW'(16 * ch), LEN_W'(16));
    start_layer('0, 4, 20);
    run_beats(32);
    finish_layer();

    // Backpressure: ofm_ready low for 5 cycles mid-run.
    push_scenario1();
    start_layer(AW'(32'h100), 4, 16);
    fork
      run_beats(16);
      begin
        repeat (5) @(negedge clk);
        ofm_ready = 1'b0;
        repeat (5) @(negedge clk);
        ofm_ready = 1'b1;
      end
    join
    finish_layer();

    // Reset mid-run aborts with no done; the restart reproduces scenario 1.
    push_scenario1();
    start_layer(AW'(32'h100), 4, 16);
    run_beats(5);
    begin
      int done_before;
      done_before = done_cnt;
      rst = 1'b1;
      #1;
      check("abort_valid", 32'(addr_valid), 32'd0);
      check("abort_addr", 32'(ofm_addr), 32'd0);
      check("abort_len", 32'(burst_len), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_write_ready", 32'(write_ready), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #3;
      check("abort_no_done", 32'(done_cnt), 32'(done_before));
    end
    push_scenario1();
    start_layer(AW'(32'h100), 4, 16);
    run_beats(16);
    finish_layer();

    // Empty layers: go straight through SETUP to DONE.
    zero_layer(4, 0);
    zero_layer(0, 16);

    repeat (2) @(negedge clk);
    #3;
    check("done_count", 32'(done_cnt), 32'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
